// File: rtl/ext_pipe.sv
// Immediate extender feeding a small result FIFO: each accepted imm/EOp pair is
// extended on entry and the stored result is presented in push order.
module ext_pipe #(
    parameter int unsigned IMM_W = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_W-1:0]         imm,
    input  logic [2:0]               EOp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         ext,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = OUT_W - IMM_W;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [OUT_W-1:0] mem_ext [DEPTH];
    logic             mem_err [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic [OUT_W-1:0] ext_d, sext;
    logic             err_d;
    logic             push, pop;

    assign in_ready  = reset && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign sext      = {{PW{imm[IMM_W-1]}}, imm};

    always_comb begin
        ext_d = '0;
        err_d = 1'b0;
        case (EOp)
            3'd0:    ext_d = {{PW{1'b0}}, imm};
            3'd1:    ext_d = sext;
            3'd2:    ext_d = {imm, {PW{1'b0}}};
            3'd3:    ext_d = sext << 2;
            3'd4:    ext_d = {{PW{1'b1}}, imm};
            default: err_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ext[wr_q] <= ext_d;
            mem_err[wr_q] <= err_d;
        end
    end

    always_comb begin
        ext = '0;
        err = 1'b0;
        if (out_valid) begin
            ext = mem_ext[rd_q];
            err = mem_err[rd_q];
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe with IMM_W=16, OUT_W=32, DEPTH=4.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  EOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext;
    logic        err;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    ext_pipe #(.IMM_W(16), .OUT_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .EOp       (EOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext       (ext),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] v_imm [9];
    logic [2:0]  v_op  [9];
    logic [31:0] v_ext [9];
    logic        v_err [9];

    logic [31:0] q [$];
    int          sent, got, mcount, cyc;
    bit          do_push, do_pop;

    initial begin
        v_imm = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234,
                  16'h7FFF, 16'h8000, 16'h8000, 16'h0005};
        v_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd3, 3'd6, 3'd0};
        v_ext = '{32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFC, 32'hFFFF1234,
                  32'h00007FFF, 32'hFFFE0000, 32'h00000000, 32'h00000005};
        v_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; imm = '0; EOp = '0;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ext", ext, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Extension modes, one entry at a time
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; imm = v_imm[i]; EOp = v_op[i];
            tick();
            in_valid = 1'b0;
            chk($sformatf("mode%0d_valid", i), out_valid, 1);
            chk($sformatf("mode%0d_ext", i), ext, v_ext[i]);
            chk($sformatf("mode%0d_err", i), err, v_err[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("mode%0d_empty", i), count, 0);
        end

        // Fill past full with consumer stalled
        EOp = 3'd0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; imm = 16'(i + 1);
            tick();
            chk($sformatf("fill%0d_count", i), count, (i < 4) ? i + 1 : 4);
        end
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_head", ext, 32'd1);
        tick();
        chk("stall_stable", ext, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_ext", i), ext, 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_ext_zero", ext, 0);

        // Simultaneous push and pop at count=2
        in_valid = 1'b1; imm = 16'h0010; tick();
        imm = 16'h0020; tick();
        imm = 16'h0030; out_ready = 1'b1;
        chk("sim_pop_value", ext, 32'h10);
        tick();
        in_valid = 1'b0;
        chk("sim_count", count, 2);
        chk("sim_next_head", ext, 32'h20);
        tick();
        chk("sim_third", ext, 32'h30);
        tick();
        out_ready = 1'b0;
        chk("sim_empty", count, 0);

        // Reset mid-stream with three entries buffered
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imm = 16'h00A0 + 16'(i);
            tick();
        end
        chk("pre_rst_count", count, 3);
        reset = 1'b0;
        tick();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_ext", ext, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        tick();
        chk("mid_rst_ignored_push", count, 0);
        reset = 1'b1;
        #1;
        chk("mid_rel_in_ready", in_ready, 1);

        // Stream 10 entries with out_ready toggling, against a queue model
        sent = 0; got = 0; mcount = 0; cyc = 0; EOp = 3'd1;
        q.delete();
        while (got < 10 && cyc < 200) begin
            out_ready = cyc[0];
            in_valid  = (sent < 10);
            imm       = 16'h0100 + 16'(sent);
            do_push   = in_valid && (mcount != 4);
            do_pop    = out_ready && (mcount != 0);
            if (do_pop) chk($sformatf("stream%0d_ext", got), ext, q[0]);
            tick();
            if (do_pop) begin
                void'(q.pop_front());
                got++;
                mcount--;
            end
            if (do_push) begin
                q.push_back(32'h0000_0100 + 32'(sent));
                sent++;
                mcount++;
            end
            chk($sformatf("stream_c%0d_count", cyc), count, mcount);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_done", got, 10);
        chk("stream_empty", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
